// File: rtl/multicycle_ctrl.sv
// Multicycle ARM control: Moore FSM, NZCV flag register, condition check, datapath selects/enables.
// Latency: LDR 5, STR 4, data-processing 4, branch 3, op=11 2 cycles; outputs combinational from state/flags/fields.
// No backpressure: advances every cycle; reset aborts the instruction and suppresses all write enables.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] aluflags,
    output logic [1:0] aluctrl,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] flags;
    logic       flag_n, flag_z, flag_c, flag_v;
    logic       condex;
    logic [3:0] cmd;
    logic [1:0] alu_dec;
    logic       cmd_ok;
    logic       cmd_arith;
    logic       in_exec;
    logic       rd_is_pc;
    logic       pc_we, ir_we, reg_we, mem_we;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;
    assign cmd       = funct[4:1];
    assign cmd_arith = (cmd == 4'b0100) || (cmd == 4'b0010);
    assign in_exec   = (state == EXECUTER) || (state == EXECUTEI);
    assign rd_is_pc  = (rd == 4'hF);
    assign state_o   = state;

    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = flag_z;
            4'b0001: condex = ~flag_z;
            4'b0010: condex = flag_c;
            4'b0011: condex = ~flag_c;
            4'b0100: condex = flag_n;
            4'b0101: condex = ~flag_n;
            4'b0110: condex = flag_v;
            4'b0111: condex = ~flag_v;
            4'b1000: condex = flag_c & ~flag_z;
            4'b1001: condex = ~flag_c | flag_z;
            4'b1010: condex = (flag_n == flag_v);
            4'b1011: condex = (flag_n != flag_v);
            4'b1100: condex = ~flag_z & (flag_n == flag_v);
            4'b1101: condex = flag_z | (flag_n != flag_v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Unsupported commands execute as ADD but never write back.
    always_comb begin
        alu_dec = 2'b00;
        cmd_ok  = 1'b1;
        case (cmd)
            4'b0100: alu_dec = 2'b00;
            4'b0010: alu_dec = 2'b01;
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
            default: cmd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= state_t'(RESET_STATE);
            flags <= 4'b0000;
        end else begin
            state <= state_nxt;
            if (in_exec && funct[0] && condex) begin
                flags[3:2] <= aluflags[3:2];
                if (cmd_arith) flags[1:0] <= aluflags[1:0];
            end
        end
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:    state_nxt = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_nxt = MEMADR;
                    2'b00:   state_nxt = funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR:   state_nxt = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_nxt = MEMWB;
            EXECUTER: state_nxt = ALUWB;
            EXECUTEI: state_nxt = ALUWB;
            default:  state_nxt = FETCH;
        endcase
    end

    always_comb begin
        aluctrl   = 2'b00;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                ir_we     = 1'b1;
                pc_we     = 1'b1;
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            MEMADR:   alusrcb = 2'b01;
            MEMREAD:  adrsrc  = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                reg_we    = condex;
                pc_we     = condex & rd_is_pc;
            end
            MEMWRITE: begin
                adrsrc = 1'b1;
                mem_we = condex;
            end
            EXECUTER: aluctrl = alu_dec;
            EXECUTEI: begin
                alusrcb = 2'b01;
                aluctrl = alu_dec;
            end
            ALUWB: begin
                reg_we = condex & cmd_ok;
                pc_we  = condex & cmd_ok & rd_is_pc;
            end
            BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                pc_we     = condex;
            end
            default: ;
        endcase
    end

    assign pcwrite  = pc_we  & ~reset;
    assign irwrite  = ir_we  & ~reset;
    assign regwrite = reg_we & ~reset;
    assign memwrite = mem_we & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model (state path per instruction class,
// ARM condition semantics, NZCV register) driven by directed cases plus random instructions.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] aluflags;
    logic [1:0] aluctrl;
    logic       pcwrite, irwrite, regwrite, memwrite, adrsrc, alusrca;
    logic [1:0] alusrcb, resultsrc;
    logic [3:0] state_o;
    logic [11:0] dut_outs;

    multicycle_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .op        (op),
        .funct     (funct),
        .rd        (rd),
        .aluflags  (aluflags),
        .aluctrl   (aluctrl),
        .pcwrite   (pcwrite),
        .irwrite   (irwrite),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .adrsrc    (adrsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    assign dut_outs = {aluctrl, pcwrite, irwrite, regwrite, memwrite,
                       adrsrc, alusrca, alusrcb, resultsrc};

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [3:0] mflags;
    int         fl_force = -1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ARM condition: pairs of (test, inverse) indexed by cond[3:1], AL/NV special.
    function automatic logic m_condex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        if (c == 4'hE) return 1'b1;
        return base ^ c[0];
    endfunction

    function automatic logic [1:0] m_alu(input logic [3:0] c);
        if (c == 4'b0010) return 2'b01;
        if (c == 4'b0000) return 2'b10;
        if (c == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic m_cmd_ok(input logic [3:0] c);
        return (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0000) || (c == 4'b1100);
    endfunction

    // Expected {aluctrl,pcwrite,irwrite,regwrite,memwrite,adrsrc,alusrca,alusrcb,resultsrc}.
    function automatic logic [11:0] m_out(input int st, input logic cx);
        logic [1:0] ac, b, res;
        logic pc, ir, rw, mw, as, aa, wb;
        ac = 2'b00; b = 2'b00; res = 2'b00;
        pc = 0; ir = 0; rw = 0; mw = 0; as = 0; aa = 0;
        case (st)
            0: begin aa = 1; b = 2'b10; res = 2'b10; ir = 1; pc = 1; end
            1: begin aa = 1; b = 2'b10; res = 2'b10; end
            2: b = 2'b01;
            3: as = 1;
            4: begin res = 2'b01; rw = cx; pc = cx && rd == 4'hF; end
            5: begin as = 1; mw = cx; end
            6: ac = m_alu(funct[4:1]);
            7: begin b = 2'b01; ac = m_alu(funct[4:1]); end
            8: begin wb = cx && m_cmd_ok(funct[4:1]); rw = wb; pc = wb && rd == 4'hF; end
            9: begin b = 2'b01; res = 2'b10; pc = cx; end
            default: ;
        endcase
        return {ac, pc, ir, rw, mw, as, aa, b, res};
    endfunction

    // Called at posedge+1; returns at the following negedge after checking.
    task automatic step(input int st);
        logic cx;
        aluflags = (fl_force < 0) ? 4'($urandom) : 4'(fl_force);
        @(negedge clk);
        cx = m_condex(cond, mflags);
        chk("state", 16'(state_o), 16'(st));
        chk($sformatf("outs_s%0d", st), 16'(dut_outs), 16'(m_out(st, cx)));
        if ((st == 6 || st == 7) && funct[0] && cx) begin
            mflags[3:2] = aluflags[3:2];
            if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) mflags[1:0] = aluflags[1:0];
        end
    endtask

    task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        int seq[$];
        cond = c; op = o; funct = f; rd = r;
        seq = '{0, 1};
        case (o)
            2'b00: begin seq.push_back(f[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (f[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: ;
        endcase
        foreach (seq[i]) begin
            step(seq[i]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; cond = 4'h0; op = 2'b00; funct = 6'h0; rd = 4'h0; aluflags = 4'h0;
        mflags = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 16'(state_o), 16'd0);
        chk("rst_we", 16'({pcwrite, irwrite, regwrite, memwrite}), 16'd0);
        chk("rst_sel", 16'({aluctrl, adrsrc, alusrca, alusrcb, resultsrc}), 16'b00_0_1_10_10);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(4'b0000, 2'b00, 6'b000100, 4'h3);             // SUBEQ with Z=0: no write
        fl_force = 4'b0100;
        run_instr(4'b1110, 2'b00, 6'b101001, 4'h2);             // ADDS imm: flags <- 0100
        fl_force = -1;
        run_instr(4'b0001, 2'b10, 6'b000000, 4'h0);             // BNE with Z=1: not taken
        run_instr(4'b1110, 2'b01, 6'b011001, 4'h1);             // LDR
        run_instr(4'b1110, 2'b01, 6'b011000, 4'h1);             // STR
        fl_force = 4'b0000;
        run_instr(4'b1110, 2'b00, 6'b001001, 4'h2);             // ADDS reg: flags <- 0000
        fl_force = -1;
        run_instr(4'b0001, 2'b10, 6'b000000, 4'h0);             // BNE with Z=0: taken
        run_instr(4'b1110, 2'b00, 6'b011000, 4'hF);             // ORR to PC
        run_instr(4'b1110, 2'b00, 6'b011110, 4'h5);             // unsupported cmd
        run_instr(4'b1110, 2'b11, 6'b000000, 4'h0);             // NOP class
        run_instr(4'b1110, 2'b01, 6'b011001, 4'hF);             // LDR to PC

        // Reset in the middle of a STR's MEMWRITE cycle.
        cond = 4'b1110; op = 2'b01; funct = 6'b011000; rd = 4'h2;
        step(0); @(posedge clk); #1;
        step(1); @(posedge clk); #1;
        step(2); @(posedge clk); #1;
        step(5);
        reset = 1'b1;
        #1;
        mflags = 4'h0;
        chk("midrst_state", 16'(state_o), 16'd0);
        chk("midrst_we", 16'({pcwrite, irwrite, regwrite, memwrite}), 16'd0);
        chk("midrst_sel", 16'({aluctrl, adrsrc, alusrca, alusrcb, resultsrc}), 16'b00_0_1_10_10);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(4'b1110, 2'b00, 6'b001000, 4'h4);

        for (int k = 0; k < 250; k++) begin
            logic [3:0] c, r;
            logic [1:0] o;
            logic [5:0] f;
            c = 4'($urandom);
            o = 2'($urandom);
            f = 6'($urandom);
            if ($urandom_range(0, 2) == 0) f[4:1] = 4'($urandom);
            else f[4:1] = m_cmd_ok(f[4:1]) ? f[4:1] : 4'b0100;
            if (o == 2'b00 && !m_cmd_ok(f[4:1])) f[0] = 1'b0;
            r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            run_instr(c, o, f, r);
        end

        @(negedge clk);
        chk("end_state", 16'(state_o), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle ARM control unit: the issuing end of the ALU's `aluctrl` interface. The ALU consumes `aluctrl` and returns flags; this block produces `aluctrl` and consumes the flags.
- Moore FSM sequences fetch/decode/execute over several cycles.
- Holds the NZCV flag register and evaluates the condition field.
- Drives datapath mux selects and write enables. Immediate/register-source decode lives in a separate decoder.

Parameters:
- RESET_STATE, 4'd0: encoding of FETCH; state register reset value.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- cond  input  4  instr[31:28]
- op  input  2  instr[27:26]
- funct  input  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (for memory ops [0]=L)
- rd  input  4  instr[15:12]
- aluflags  input  4  {N,Z,C,V} from ALU, current cycle
- aluctrl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- pcwrite  output  1  PC register enable
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write enable
- memwrite  output  1  data memory write enable
- adrsrc  output  1  0=PC, 1=ALU result as memory address
- alusrca  output  1  0=register A, 1=PC
- alusrcb  output  2  00=reg B, 01=extended imm, 10=constant 4
- resultsrc  output  2  00=ALUOut reg, 01=data reg, 10=ALU result
- state_o  output  4  current state, debug/verification

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10-15 are unused and go to FETCH next cycle.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - op=01 -> MEMADR
    - op=00, funct[5]=0 -> EXECUTER
    - op=00, funct[5]=1 -> EXECUTEI
    - op=10 -> BRANCH
    - op=11 -> FETCH (NOP)
  - MEMADR: funct[0]=1 -> MEMREAD, funct[0]=0 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Instruction latency: LDR 5 cycles, STR 4, data-processing 4, branch 3, op=11 2.
- Per-state outputs (unlisted signals default to 0; aluctrl defaults to ADD):
  - FETCH: adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10, irwrite=1, pcwrite=1.
  - DECODE: alusrca=1, alusrcb=10, resultsrc=10.
  - MEMADR: alusrca=0, alusrcb=01.
  - MEMREAD: adrsrc=1, resultsrc=00.
  - MEMWB: resultsrc=01, regwrite=condex.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=condex.
  - EXECUTER: alusrca=0, alusrcb=00, ALU-decode active.
  - EXECUTEI: alusrca=0, alusrcb=01, ALU-decode active.
  - ALUWB: resultsrc=00, regwrite=condex.
  - BRANCH: alusrca=0, alusrcb=01, resultsrc=10, pcwrite=condex.
- PC-destination writes: in MEMWB/ALUWB with rd=4'hF and condex=1, pcwrite=1 as well as regwrite.
- ALU decode (EXECUTER/EXECUTEI only), cmd = funct[4:1]:
  - 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11.
  - Any other cmd -> 00, and regwrite in the following ALUWB is suppressed.
- Flag register {N,Z,C,V}:
  - Updates on the clk rising edge only in EXECUTER/EXECUTEI, only when funct[0]=1 and condex=1.
  - N,Z always load; C,V load only for ADD/SUB.
  - Reset value 4'b0000.
- condex, combinational from the flag register and cond:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1; 1111 -> 0.
- A failed condition still walks the full state path; only the write enables are suppressed.
- Reset:
  - Asynchronous, forces state=FETCH and flags=0.
  - While reset=1, pcwrite, irwrite, regwrite and memwrite are forced 0; mux selects and aluctrl show FETCH values.
  - Deassertion mid-instruction restarts at FETCH; no partial write completes.
- Every output is combinational from state, registered flags and instruction fields; nothing depends combinationally on aluflags.

Test Plan:
- Reset asserted mid-MEMWRITE -> state_o=0 immediately, memwrite=0 in the same cycle; after release, FETCH has irwrite=1 and pcwrite=1.
- ADDS: op=00, funct=101001, cond=1110, aluflags=0100 -> states 0,1,7,8; aluctrl=00 in state 7; flags=0100 after state 7; regwrite=1 in state 8.
- SUB: cond=0000 with Z=0, funct=000100 -> states 0,1,6,8, aluctrl=01; regwrite=0 in ALUWB.
- LDR: op=01, funct=011001 -> states 0,1,2,3,4; adrsrc=1 in state 3; resultsrc=01 and regwrite=1 in state 4. STR (funct[0]=0) -> states 0,1,2,5 with memwrite=1.
- Branch: op=10, cond=0001 -> pcwrite=1 in BRANCH when Z=0 and 0 when Z=1; next state FETCH both times.
- ORR to PC: funct=011000, rd=4'hF -> aluctrl=11; pcwrite=1 and regwrite=1 in ALUWB. Unsupported cmd 1111 -> aluctrl=00 and regwrite=0.
